bram_stream_ctrl: RTL and testbench
===================================

# bram_stream_ctrl

Initiator-side controller for the 256x16 block RAM primitive (SB_RAM256x16): drives WADDR/WDATA/WE/WCLKE to load a table from a valid/ready input stream, and drives RADDR/RE/RCLKE to play a table region out as a valid/ready output stream. It absorbs the RAM's one-cycle registered read latency and applies output backpressure without dropping words. It sits between a sample producer/consumer and one RAM instance, both on the same clock.

## Interface
- ADDR_W, 8, RAM address width (depth 2^ADDR_W)
- DATA_W, 16, RAM/stream word width
- clk  in  1  single clock; RAM WCLK and RCLK are tied to it externally
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse: begin loading from address 0
- load_len  in  ADDR_W  words to load minus 1 (0 → 1 word, 255 → 256)
- in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W  load stream
- load_done  out  1  one-cycle pulse after the last write
- play_start  in  1  pulse: begin playback
- play_base  in  ADDR_W  first read address
- play_len  in  ADDR_W  words to play minus 1
- play_loop  in  1  sampled with play_start; restart at play_base after the last word
- play_stop  in  1  end looping playback after the current pass
- out_valid / out_ready / out_data  out / in / out  1 / 1 / DATA_W  playback stream
- busy  out  1  state ≠ IDLE or output buffer non-empty
- ram_waddr, ram_wdata, ram_we, ram_wclke  out  ADDR_W, DATA_W, 1, 1
- ram_raddr, ram_re, ram_rclke  out  ADDR_W, 1, 1
- ram_mask  out  DATA_W  constant 0
- ram_rdata  in  DATA_W

## Operation
- States: IDLE, LOAD, PLAY.
- IDLE: load_start → LOAD (wptr=0, wcnt=load_len). Else play_start → PLAY (rptr=play_base, rcnt=play_len, loop latched). If both pulse together, load wins and play_start is dropped. Starts outside IDLE are ignored.
- LOAD: in_ready=1. On each in_valid&&in_ready: ram_we=ram_wclke=1, ram_waddr=wptr, ram_wdata=in_data; wptr++. The write of word wcnt → IDLE, with load_done pulsed the following cycle.
- PLAY: issue a read (ram_re=ram_rclke=1, ram_raddr=rptr) when occupancy + in_flight − pop < 2. Each read increments rptr modulo 2^ADDR_W (base 0xF0, len 0x1F wraps to 0x0F). After the last address: if loop is set and play_stop has not been seen since entry, reload rptr/rcnt; otherwise stop issuing and → IDLE. Data already in flight still drains.
- Returned data: the word captured one cycle after issue enters a 2-entry output buffer. out_data is the head entry and stays stable while out_valid && !out_ready.
- ram_we is 0 outside LOAD. ram_re is 0 outside PLAY.

## Timing
- Reset: state IDLE, all RAM control outputs 0, addresses/data 0, in_ready 0, out_valid 0, load_done 0, busy 0. Reset mid-LOAD leaves partially written RAM contents. Reset mid-PLAY discards buffered words.
- Load: 1 word/cycle. in_ready rises the cycle after load_start. in_ready falls the cycle after the last write.
- Play latency: play_start sampled at edge E0 → first ram_re during E0–E1 → ram_rdata valid after E1 → out_valid high after E2.
- Throughput is 1 word/cycle with out_ready held high. No word is lost or duplicated under arbitrary out_ready patterns.
- Loop restart adds no bubble.

## Structure
- Package bram_ctrl_pkg: state enum (IDLE/LOAD/PLAY), DEPTH = 2**ADDR_W, default widths.
- Sub-module bram_ctrl_skid: 2-entry valid/ready buffer with occupancy output, used for the playback path.

## Test plan
- Load 4 words 0x1111..0x4444 (load_len=3), then play base 0, len 3 → out 0x1111,0x2222,0x3333,0x4444; load_done one pulse; first out_valid 2 edges after play_start.
- Play base 0xFE, len 3 on a ramp-preloaded RAM (mem[a]=a) → out 0x00FE,0x00FF,0x0000,0x0001 (wrap-around).
- Random out_ready with 30% low duty over a 256-word play → exact ordered sequence, with out_data stable while stalled.
- play_loop=1, len 1, play_stop asserted after 5 words → sequence A,B,A,B,A,B, then busy falls.
- load_start and play_start in the same cycle → LOAD entered and no ram_re; play_start during LOAD → ignored.
- rst_n low mid-PLAY → out_valid and ram_re drop immediately; after release, state is IDLE and busy=0.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// Shared types and default widths for the block-RAM stream controller.
package bram_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

endpackage

// File: rtl/bram_ctrl_skid.sv
// Two-entry valid/ready buffer on the playback path; reports its occupancy
// so the read issuer can keep the RAM pipeline from overrunning it.
module bram_ctrl_skid #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = count;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_ctrl.sv
// Loads a 256x16 block RAM from a valid/ready stream and plays a region of it
// back as a valid/ready stream, hiding the RAM's one-cycle read latency.
module bram_stream_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              load_done,
    input  logic              play_start,
    input  logic [ADDR_W-1:0] play_base,
    input  logic [ADDR_W-1:0] play_len,
    input  logic              play_loop,
    input  logic              play_stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_wclke,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_re,
    output logic              ram_rclke,
    output logic [DATA_W-1:0] ram_mask,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_PLAY = PLAY;

    // Handshake rule for both streams: a word moves on a rising edge where
    // valid and ready are both high; valid never depends on ready.

    logic [1:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] ridx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic              loop_q;
    logic              stop_seen;
    logic              in_flight;
    logic [1:0]        occ;
    logic              skid_in_ready;
    logic              wr_fire;
    logic              rd_issue;
    logic              pop;

    assign in_ready  = (state == ST_LOAD);
    assign wr_fire   = in_ready && in_valid;
    assign pop       = out_valid && out_ready;

    // Buffer slots already committed (held or in flight) must stay below two
    // after this cycle's pop, so a returning word always finds room.
    assign rd_issue  = (state == ST_PLAY) &&
                       (({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));

    assign ram_we    = wr_fire;
    assign ram_wclke = wr_fire;
    assign ram_waddr = wptr;
    assign ram_wdata = wr_fire ? in_data : '0;
    assign ram_re    = rd_issue;
    assign ram_rclke = rd_issue;
    assign ram_raddr = rptr;
    assign ram_mask  = '0;
    assign busy      = (state != ST_IDLE) || (occ != 2'd0) || in_flight;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            wcnt      <= '0;
            rptr      <= '0;
            ridx      <= '0;
            base_q    <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            stop_seen <= 1'b0;
            in_flight <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            in_flight <= rd_issue;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state <= ST_LOAD;
                        wptr  <= '0;
                        wcnt  <= load_len;
                    end else if (play_start) begin
                        state     <= ST_PLAY;
                        rptr      <= play_base;
                        base_q    <= play_base;
                        len_q     <= play_len;
                        ridx      <= '0;
                        loop_q    <= play_loop;
                        stop_seen <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (wr_fire) begin
                        wptr <= wptr + ADDR_W'(1);
                        if (wptr == wcnt) begin
                            state     <= ST_IDLE;
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (play_stop) begin
                        stop_seen <= 1'b1;
                    end
                    if (rd_issue) begin
                        if (ridx == len_q) begin
                            if (loop_q && !(stop_seen || play_stop)) begin
                                rptr <= base_q;
                                ridx <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            rptr <= rptr + ADDR_W'(1);
                            ridx <= ridx + ADDR_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bram_ctrl_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_flight),
        .in_ready  (skid_in_ready),
        .in_data   (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occ)
    );

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Bench for bram_stream_ctrl: behavioural RAM, shadow table of loaded words,
// and an ordered queue of the words the playback stream must deliver.
module tb_bram_stream_ctrl;
    import bram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start, in_valid, play_start, play_loop, play_stop, out_ready;
    logic [7:0]  load_len, play_base, play_len;
    logic [15:0] in_data;
    logic        in_ready, load_done, out_valid, busy;
    logic [15:0] out_data;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [15:0] ram_wdata, ram_mask, ram_rdata;
    logic        ram_we, ram_wclke, ram_re, ram_rclke;
    logic [1:0]  state_dbg;

    logic [15:0] ram [256];
    logic [15:0] ref_mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] ld_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          re_cnt = 0;
    logic        rdy_mode = 1'b0;
    logic        rdy_val = 1'b1;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_data = '0;

    bram_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .load_done(load_done),
        .play_start(play_start), .play_base(play_base), .play_len(play_len),
        .play_loop(play_loop), .play_stop(play_stop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_wclke(ram_wclke),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rclke(ram_rclke),
        .ram_mask(ram_mask), .ram_rdata(ram_rdata),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // SB_RAM256x16 behaviour: registered write and registered read
    always @(posedge clk) begin
        if (ram_we && ram_wclke) ram[ram_waddr] <= ram_wdata;
        if (ram_re && ram_rclke) ram_rdata <= ram[ram_raddr];
    end

    always @(posedge clk) begin
        #1;
        out_ready = rdy_mode ? ($urandom_range(0, 99) >= 30) : rdy_val;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: every accepted output word against the expected queue
    always @(negedge clk) begin
        if (ram_re) re_cnt++;
        if (rst_n) begin
            if (stall_prev) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_word", 32'(exp_q.size()), 32'd1);
                else check_eq("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // driver tasks
    task automatic start_load(input logic [7:0] len_m1);
        @(posedge clk); #1;
        load_start = 1'b1;
        load_len   = len_m1;
        @(posedge clk); #1;
        load_start = 1'b0;
        check_eq("in_ready_rise", 32'(in_ready), 32'd1);
    endtask

    task automatic feed_words(input int n_words);
        int   idx = 0;
        int   cyc = 0;
        logic fire;
        while (idx < n_words && cyc < 4 * n_words + 50) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = ld_q[idx];
            fire     = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) begin
                ref_mem[idx] = ld_q[idx];
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("load_count", 32'(idx), 32'(n_words));
        check_eq("in_ready_fall", 32'(in_ready), 32'd0);
        check_eq("load_done_pulse", 32'(load_done), 32'd1);
        check_eq("load_state_idle", 32'(state_dbg), 32'(IDLE));
        @(posedge clk); #1;
        check_eq("load_done_single", 32'(load_done), 32'd0);
    endtask

    task automatic begin_play(input logic [7:0] base, input logic [7:0] len_m1, input logic loop_en);
        if (!loop_en) begin
            for (int i = 0; i <= int'(len_m1); i++) begin
                exp_q.push_back(ref_mem[(int'(base) + i) % 256]);
            end
        end
        @(posedge clk); #1;
        play_start = 1'b1;
        play_base  = base;
        play_len   = len_m1;
        play_loop  = loop_en;
        @(posedge clk); #1;
        play_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] wa, wb;
        rst_n = 1'b0;
        load_start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
        play_start = 1'b0; play_base = '0; play_len = '0; play_loop = 1'b0; play_stop = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        in_data = 16'hFFFF;
        #3;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_we", 32'(ram_we), 32'd0);
        check_eq("rst_wclke", 32'(ram_wclke), 32'd0);
        check_eq("rst_re", 32'(ram_re), 32'd0);
        check_eq("rst_rclke", 32'(ram_rclke), 32'd0);
        check_eq("rst_wdata", 32'(ram_wdata), 32'd0);
        check_eq("rst_waddr", 32'(ram_waddr), 32'd0);
        check_eq("rst_raddr", 32'(ram_raddr), 32'd0);
        check_eq("rst_load_done", 32'(load_done), 32'd0);
        check_eq("rst_mask", 32'(ram_mask), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
        in_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // four-word load then play with latency check
        ld_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        start_load(8'd3);
        feed_words(4);
        begin_play(8'd0, 8'd3, 1'b0);
        check_eq("lat_e0_re", 32'(ram_re), 32'd1);
        check_eq("lat_e0_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("lat_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("lat_e2_valid", 32'(out_valid), 32'd1);
        wait_idle("play4", 200);

        // simultaneous starts: load wins, play during load ignored
        re_cnt = 0;
        @(posedge clk); #1;
        load_start = 1'b1; play_start = 1'b1; load_len = 8'd1; play_base = 8'd0; play_len = 8'd3;
        @(posedge clk); #1;
        load_start = 1'b0; play_start = 1'b0;
        check_eq("both_state_load", 32'(state_dbg), 32'(LOAD));
        check_eq("both_no_re", 32'(ram_re), 32'd0);
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        check_eq("ign_state_load", 32'(state_dbg), 32'(LOAD));
        ld_q = '{16'hAAAA, 16'hBBBB};
        feed_words(2);
        repeat (4) @(posedge clk);
        #1;
        check_eq("ign_re_count", 32'(re_cnt), 32'd0);
        check_eq("ign_out_valid", 32'(out_valid), 32'd0);
        check_eq("ign_busy", 32'(busy), 32'd0);

        // ramp table, wrap-around play
        ld_q.delete();
        for (int i = 0; i < 256; i++) ld_q.push_back(16'(i));
        start_load(8'd255);
        feed_words(256);
        begin_play(8'hFE, 8'd3, 1'b0);
        wait_idle("wrap", 200);

        // looping play stopped after the pass that contains the fifth word
        b  = 8'($urandom_range(0, 255));
        wa = ref_mem[b];
        wb = ref_mem[8'(b + 8'd1)];
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(wa);
            exp_q.push_back(wb);
        end
        @(negedge clk); rdy_val = 1'b0;
        begin_play(b, 8'd1, 1'b1);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rdy_val = 1'b1;
            @(negedge clk);
            rdy_val = 1'b0;
            repeat (4) @(negedge clk);
        end
        @(posedge clk); #1;
        play_stop = 1'b1;
        @(posedge clk); #1;
        play_stop = 1'b0;
        @(negedge clk); rdy_val = 1'b1;
        wait_idle("loop", 200);

        // random table, full-depth and random plays under random backpressure
        ld_q.delete();
        for (int i = 0; i < 256; i++) ld_q.push_back(16'($urandom));
        start_load(8'd255);
        feed_words(256);
        rdy_mode = 1'b1;
        begin_play(8'($urandom_range(0, 255)), 8'd255, 1'b0);
        wait_idle("full", 3000);
        for (int k = 0; k < 4; k++) begin
            begin_play(8'($urandom_range(0, 255)), 8'($urandom_range(0, 40)), 1'b0);
            wait_idle("rand", 1000);
        end

        // reset in the middle of playback
        begin_play(8'($urandom_range(0, 255)), 8'd255, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstp_out_valid", 32'(out_valid), 32'd0);
        check_eq("rstp_re", 32'(ram_re), 32'd0);
        check_eq("rstp_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        re_cnt = 0;
        @(posedge clk); #1;
        check_eq("rstp_state", 32'(state_dbg), 32'(IDLE));
        check_eq("rstp_busy_after", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rstp_re_after", 32'(re_cnt), 32'd0);
        check_eq("rstp_valid_after", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
